// File: rtl/ili9341_spi_reader.sv
// ILI9341 SPI read-transaction engine (SPI mode 0, MSB first).
// Sends one command byte with DC low, optionally clocks one dummy bit, then
// shifts 1..MAX_BYTES response bytes in from the panel's SDO line.
// Handshake: i_rd_start is a request that is sampled only while the engine is
// idle. o_busy is high from the accept edge through the DONE cycle.
// o_rd_done pulses for one cycle, and o_rd_data is valid from that cycle until
// the next accepted request.
module ili9341_spi_reader #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rd_start,
  input  logic [7:0]             i_rd_cmd,
  input  logic [2:0]             i_rd_len,
  input  logic                   i_rd_dummy,
  input  logic                   i_miso,
  output logic                   o_sck,
  output logic                   o_cs_n,
  output logic                   o_dc,
  output logic                   o_mosi,
  output logic                   o_busy,
  output logic                   o_rd_done,
  output logic [8*MAX_BYTES-1:0] o_rd_data,
  output logic [2:0]             o_state
);

  localparam int DW = 8 * MAX_BYTES;
  localparam int HW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(8 * MAX_BYTES);
  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          half_q, half_d;     // 0 = low half of a bit, 1 = high half
  logic [BW-1:0] bcnt_q, bcnt_d;     // bits remaining in the phase, minus one
  logic [7:0]    cmd_q, cmd_d;       // command shifter, MSB is on the wire
  logic [LW-1:0] len_q, len_d;       // response length after clamping
  logic          dummy_q, dummy_d;
  logic [DW-1:0] data_q, data_d;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic          dc_q, dc_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [BW-1:0] read_bits_m1;

  // Reload value for the bit counter when entering READ: 8*len - 1.
  always_comb begin
    read_bits_m1 = BW'((int'(len_q) * 8) - 1);
  end

  // Next-state and next-output logic. Every output is computed here and registered.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    half_d  = half_q;
    bcnt_d  = bcnt_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    dummy_d = dummy_q;
    data_d  = data_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rd_start) begin
          cmd_d   = i_rd_cmd;
          dummy_d = i_rd_dummy;
          // A length of 0 still reads one byte. Longer requests are clamped to the data width.
          if (i_rd_len == 3'd0)                len_d = LW'(1);
          else if (int'(i_rd_len) > MAX_BYTES) len_d = LW'(MAX_BYTES);
          else                                 len_d = LW'(i_rd_len);
          data_d  = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          dc_d    = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = i_rd_cmd[7];
          hcnt_d  = HALF_RELOAD;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (hcnt_q == '0) begin
          state_d = S_CMD;
          hcnt_d  = HALF_RELOAD;
          half_d  = 1'b0;
          bcnt_d  = BW'(7);
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end

      S_CMD, S_DUMMY, S_READ: begin
        if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - 1'b1;
        end else if (!half_q) begin
          half_d = 1'b1;
          sck_d  = 1'b1;
          hcnt_d = HALF_RELOAD;
        end else begin
          // End of the high half: this is the capture edge, and a new low half starts.
          half_d = 1'b0;
          sck_d  = 1'b0;
          hcnt_d = HALF_RELOAD;
          if (state_q == S_READ) data_d = {data_q[DW-2:0], i_miso};
          if (bcnt_q != '0) begin
            bcnt_d = bcnt_q - 1'b1;
            if (state_q == S_CMD) begin
              cmd_d  = {cmd_q[6:0], 1'b0};
              mosi_d = cmd_q[6];
            end
          end else begin
            mosi_d = 1'b0;
            dc_d   = 1'b1;
            case (state_q)
              S_CMD: begin
                if (dummy_q) begin
                  state_d = S_DUMMY;
                  bcnt_d  = '0;
                end else begin
                  state_d = S_READ;
                  bcnt_d  = read_bits_m1;
                end
              end
              S_DUMMY: begin
                state_d = S_READ;
                bcnt_d  = read_bits_m1;
              end
              default: state_d = S_HOLD;
            endcase
          end
        end
      end

      S_HOLD: begin
        if (hcnt_q == '0) begin
          state_d = S_DONE;
          cs_n_d  = 1'b1;
          dc_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        dc_d    = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset takes priority over everything and aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      half_q  <= 1'b0;
      bcnt_q  <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      dummy_q <= 1'b0;
      data_q  <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      half_q  <= half_d;
      bcnt_q  <= bcnt_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      dummy_q <= dummy_d;
      data_q  <= data_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_sck     = sck_q;
  assign o_cs_n    = cs_n_q;
  assign o_dc      = dc_q;
  assign o_mosi    = mosi_q;
  assign o_busy    = busy_q;
  assign o_rd_done = done_q;
  assign o_rd_data = data_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_ili9341_spi_reader.sv
// Bench for ili9341_spi_reader. Instance A uses CLK_DIV=2 and instance B uses
// CLK_DIV=1. Each instance has a panel model that drives SDO on the falling
// edges of SCK. The panel drives 1s during the command and dummy bits, so a
// stray capture there corrupts the result.
module tb_ili9341_spi_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- DUT A (CLK_DIV=2) ----------------
  logic        start_a = 1'b0, dummy_a = 1'b0, miso_a = 1'b1;
  logic [7:0]  cmd_a = '0;
  logic [2:0]  len_a = '0;
  logic        sck_a, cs_n_a, dc_a, mosi_a, busy_a, done_a;
  logic [31:0] data_a;
  logic [2:0]  state_a;

  ili9341_spi_reader #(.CLK_DIV(2), .MAX_BYTES(4)) u_dut_a (
    .clk(clk), .rst(rst), .i_rd_start(start_a), .i_rd_cmd(cmd_a), .i_rd_len(len_a),
    .i_rd_dummy(dummy_a), .i_miso(miso_a), .o_sck(sck_a), .o_cs_n(cs_n_a), .o_dc(dc_a),
    .o_mosi(mosi_a), .o_busy(busy_a), .o_rd_done(done_a), .o_rd_data(data_a), .o_state(state_a)
  );

  // ---------------- DUT B (CLK_DIV=1) ----------------
  logic        start_b = 1'b0, dummy_b = 1'b0, miso_b = 1'b1;
  logic [7:0]  cmd_b = '0;
  logic [2:0]  len_b = '0;
  logic        sck_b, cs_n_b, dc_b, mosi_b, busy_b, done_b;
  logic [31:0] data_b;
  logic [2:0]  state_b;

  ili9341_spi_reader #(.CLK_DIV(1), .MAX_BYTES(4)) u_dut_b (
    .clk(clk), .rst(rst), .i_rd_start(start_b), .i_rd_cmd(cmd_b), .i_rd_len(len_b),
    .i_rd_dummy(dummy_b), .i_miso(miso_b), .o_sck(sck_b), .o_cs_n(cs_n_b), .o_dc(dc_b),
    .o_mosi(mosi_b), .o_busy(busy_b), .o_rd_done(done_b), .o_rd_data(data_b), .o_state(state_b)
  );

  // ---------------- panel models ----------------
  // Response bytes are MSB-first in p_resp (first byte in [31:24]). Bit k of the
  // transaction is presented after the k-th SCK falling edge.
  logic [31:0] p_resp_a = '0, p_resp_b = '0;
  logic        p_dummy_a = 1'b0, p_dummy_b = 1'b0;
  int          fall_a = 0, fall_b = 0;

  always @(negedge sck_a or posedge cs_n_a) begin
    if (cs_n_a) begin
      fall_a = 0;
      miso_a = 1'b1;
    end else begin
      fall_a++;
      if (fall_a >= 8 + int'(p_dummy_a)) begin
        int j;
        j = fall_a - 8 - int'(p_dummy_a);
        miso_a = (j < 32) ? p_resp_a[31-j] : 1'b0;
      end else begin
        miso_a = 1'b1;
      end
    end
  end

  always @(negedge sck_b or posedge cs_n_b) begin
    if (cs_n_b) begin
      fall_b = 0;
      miso_b = 1'b1;
    end else begin
      fall_b++;
      if (fall_b >= 8 + int'(p_dummy_b)) begin
        int j;
        j = fall_b - 8 - int'(p_dummy_b);
        miso_b = (j < 32) ? p_resp_b[31-j] : 1'b0;
      end else begin
        miso_b = 1'b1;
      end
    end
  end

  // ---------------- scoreboards ----------------
  logic [31:0] exp_q_a[$];
  int          exp_lat_q_a[$];
  logic [7:0]  exp_cmd_q_a[$];
  logic [31:0] exp_q_b[$];
  int          exp_lat_q_b[$];
  logic [7:0]  exp_cmd_q_b[$];

  // Monitor A: tracks one transaction from the rise of busy through the done
  // pulse, then pops the next expectation and compares.
  logic       in_a = 1'b0, prev_sck_a = 1'b0, csbad_a = 1'b0;
  logic [7:0] cmdbits_a = '0;
  int         cmdrise_a = 0, t0_a = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_a       = 1'b0;
      prev_sck_a = 1'b0;
    end else begin
      if (busy_a && !in_a) begin
        in_a = 1'b1; t0_a = cyc; csbad_a = 1'b0; cmdbits_a = '0; cmdrise_a = 0;
      end
      if (in_a) begin
        if (cs_n_a && !done_a) csbad_a = 1'b1;
        if (sck_a && !prev_sck_a && !dc_a) begin
          cmdbits_a = {cmdbits_a[6:0], mosi_a};
          cmdrise_a++;
        end
      end
      if (done_a) begin
        if (exp_q_a.size() == 0) begin
          check("a_unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [31:0] ed;
          int          el;
          logic [7:0]  ec;
          ed = exp_q_a.pop_front();
          el = exp_lat_q_a.pop_front();
          ec = exp_cmd_q_a.pop_front();
          check("a_rd_data", data_a, ed);
          check("a_latency", cyc - t0_a, el);
          check("a_mosi_cmd", {24'd0, cmdbits_a}, {24'd0, ec});
          check("a_cmd_bit_count", cmdrise_a, 32'd8);
          check("a_cs_low_span", {31'd0, csbad_a}, 32'd0);
        end
        in_a = 1'b0;
      end
      prev_sck_a = sck_a;
    end
  end

  // Monitor B: the same checks as monitor A, plus SCK period and duty cycle at CLK_DIV=1.
  logic       in_b = 1'b0, prev_sck_b = 1'b0, csbad_b = 1'b0, dblhigh_b = 1'b0;
  logic [7:0] cmdbits_b = '0;
  int         cmdrise_b = 0, rise_b = 0, high_b = 0, t0_b = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_b       = 1'b0;
      prev_sck_b = 1'b0;
    end else begin
      if (busy_b && !in_b) begin
        in_b = 1'b1; t0_b = cyc; csbad_b = 1'b0; dblhigh_b = 1'b0;
        cmdbits_b = '0; cmdrise_b = 0; rise_b = 0; high_b = 0;
      end
      if (in_b) begin
        if (cs_n_b && !done_b) csbad_b = 1'b1;
        if (sck_b) high_b++;
        if (sck_b && prev_sck_b) dblhigh_b = 1'b1;
        if (sck_b && !prev_sck_b) begin
          rise_b++;
          if (!dc_b) begin
            cmdbits_b = {cmdbits_b[6:0], mosi_b};
            cmdrise_b++;
          end
        end
      end
      if (done_b) begin
        if (exp_q_b.size() == 0) begin
          check("b_unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [31:0] ed;
          int          el;
          logic [7:0]  ec;
          ed = exp_q_b.pop_front();
          el = exp_lat_q_b.pop_front();
          ec = exp_cmd_q_b.pop_front();
          check("b_rd_data", data_b, ed);
          check("b_latency", cyc - t0_b, el);
          check("b_mosi_cmd", {24'd0, cmdbits_b}, {24'd0, ec});
          check("b_cmd_bit_count", cmdrise_b, 32'd8);
          check("b_sck_rises", rise_b, 32'd16);
          check("b_sck_high_cycles", high_b, 32'd16);
          check("b_sck_double_high", {31'd0, dblhigh_b}, 32'd0);
          check("b_cs_low_span", {31'd0, csbad_b}, 32'd0);
        end
        in_b = 1'b0;
      end
      prev_sck_b = sck_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_a(input logic [7:0] cmd, input logic [2:0] len, input logic dummy,
                         input logic [31:0] resp, input logic [31:0] exp_data, input int exp_lat);
    p_resp_a  = resp;
    p_dummy_a = dummy;
    exp_q_a.push_back(exp_data);
    exp_lat_q_a.push_back(exp_lat);
    exp_cmd_q_a.push_back(cmd);
    @(negedge clk);
    start_a = 1'b1; cmd_a = cmd; len_a = len; dummy_a = dummy;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic drain_a(input int budget);
    for (int i = 0; i < budget && exp_q_a.size() != 0; i++) @(negedge clk);
    check("a_drain", exp_q_a.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic issue_b(input logic [7:0] cmd, input logic [2:0] len, input logic dummy,
                         input logic [31:0] resp, input logic [31:0] exp_data, input int exp_lat);
    p_resp_b  = resp;
    p_dummy_b = dummy;
    exp_q_b.push_back(exp_data);
    exp_lat_q_b.push_back(exp_lat);
    exp_cmd_q_b.push_back(cmd);
    @(negedge clk);
    start_b = 1'b1; cmd_b = cmd; len_b = len; dummy_b = dummy;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic drain_b(input int budget);
    for (int i = 0; i < budget && exp_q_b.size() != 0; i++) @(negedge clk);
    check("b_drain", exp_q_b.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'd0, cs_n_a}, 32'd1);
    check("rst_sck", {31'd0, sck_a}, 32'd0);
    check("rst_dc", {31'd0, dc_a}, 32'd1);
    check("rst_mosi", {31'd0, mosi_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_data", data_a, 32'd0);
    check("rst_state", {29'd0, state_a}, 32'd0);
    check("rst_b_cs_n", {31'd0, cs_n_b}, 32'd1);
    check("rst_b_busy", {31'd0, busy_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // RDDID with dummy bit, 3 bytes: 2*(2+2*(8+1+24)) = 136
    issue_a(8'h04, 3'd3, 1'b1, 32'h00934100, 32'h00009341, 136);
    drain_a(400);

    // RDDST with dummy bit, 4 bytes: 2*(2+2*(8+1+32)) = 168
    issue_a(8'h09, 3'd4, 1'b1, 32'h80530400, 32'h80530400, 168);
    drain_a(400);

    // 2 bytes with no dummy bit: 2*(2+2*(8+16)) = 100. A start with cmd 0xFF while busy must be ignored.
    issue_a(8'h04, 3'd2, 1'b0, 32'hA55A0000, 32'h0000A55A, 100);
    repeat (9) @(negedge clk);
    start_a = 1'b1; cmd_a = 8'hFF; len_a = 3'd1; dummy_a = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    drain_a(400);
    repeat (3) @(negedge clk);
    check("busy_start_ignored_busy", {31'd0, busy_a}, 32'd0);
    check("busy_start_ignored_state", {29'd0, state_a}, 32'd0);

    // Abort during READ with reset. No expectation is queued, so a done pulse would be reported.
    p_resp_a = 32'hDEADBEEF; p_dummy_a = 1'b1;
    @(negedge clk);
    start_a = 1'b1; cmd_a = 8'h09; len_a = 3'd4; dummy_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (58) @(negedge clk);
    check("abort_in_read", {29'd0, state_a}, 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", {31'd0, cs_n_a}, 32'd1);
    check("abort_sck", {31'd0, sck_a}, 32'd0);
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_data", data_a, 32'd0);
    check("abort_done", {31'd0, done_a}, 32'd0);
    check("abort_dc", {31'd0, dc_a}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_stays_idle", {29'd0, state_a}, 32'd0);

    // A new transaction after the abort: 2*(2+2*(8+8)) = 68
    issue_a(8'h0A, 3'd1, 1'b0, 32'h3C000000, 32'h0000003C, 68);
    drain_a(400);

    // len=0 is read as 1 byte. The second byte 0xFF must not appear in the result.
    issue_a(8'h04, 3'd0, 1'b0, 32'hC3FF0000, 32'h000000C3, 68);
    drain_a(400);

    // len=7 is clamped to 4 bytes: 168
    issue_a(8'h09, 3'd7, 1'b1, 32'h12345678, 32'h12345678, 168);
    drain_a(400);

    // CLK_DIV=1, 1 byte, no dummy bit: 1*(2+2*16) = 34
    issue_b(8'h0A, 3'd1, 1'b0, 32'h9C000000, 32'h0000009C, 34);
    drain_b(200);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
